// File: rtl/hs_channel_arbiter.sv
// hs_channel_arbiter
// Round-robin arbiter/sequencer sharing one pulse-handshake CDC channel among
// N write-domain requesters. A grant latches the winner's payload and index
// into holding registers that stay stable for the read domain, pulses
// hs_start, waits for hs_done and then pulses the winner's ack.
//
// Optional feature: define HS_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles; an expired wait still acks the requester and raises the
// sticky timeout_err output.
module hs_channel_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         ack,
  output logic                 hs_start,
  input  logic                 hs_done,
  output logic [W-1:0]         xfer_data,
  output logic [$clog2(N)-1:0] xfer_id,
  output logic                 busy
`ifdef HS_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0]   N_W    = (IW+1)'(N);
  localparam logic [IW-1:0] ID_MAX = IW'(N-1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   rr_ptr_reg;
  logic [N-1:0]    ack_reg;
  logic            hs_start_reg;
  logic [W-1:0]    xfer_data_reg;
  logic [IW-1:0]   xfer_id_reg;

  // Request vector duplicated so that a part-select starting at rr_ptr is a
  // rotation with explicit wrap, valid for any N (not only powers of two).
  logic [2*N-2:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [N-1:0]    req_first;
  logic            grant_any;
  logic [IW-1:0]   rot_pos;
  logic [IW:0]     grant_sum;
  logic [IW-1:0]   grant_idx;
  logic [W-1:0]    grant_data;
  logic [N-1:0]    ack_onehot;
  logic [IW-1:0]   rr_next;
  logic            wait_expired;

  assign req_dbl   = {req[N-2:0], req};
  assign req_rot   = req_dbl[rr_ptr_reg +: N];
  // Isolate the lowest set bit of the rotated vector: first requester at or
  // after rr_ptr.
  assign req_first = req_rot & (~req_rot + N'(1));
  assign grant_any = |req_rot;

  // Encode the one-hot winner position back to a rotated index.
  always_comb begin
    rot_pos = '0;
    for (int k = 0; k < N; k++) begin
      if (req_first[k]) rot_pos = IW'(k);
    end
  end

  // Undo the rotation; the sum can reach 2N-2, so subtract N once on overflow.
  assign grant_sum = {1'b0, rot_pos} + {1'b0, rr_ptr_reg};
  assign grant_idx = (grant_sum >= N_W) ? IW'(grant_sum - N_W) : grant_sum[IW-1:0];

  // Select the winner's payload slice.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == IW'(k)) grant_data = req_data[k*W +: W];
    end
  end

  // One-hot ack pattern for the requester currently being served.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ack
      assign ack_onehot[gi] = (xfer_id_reg == IW'(gi));
    end
  endgenerate

  assign rr_next = (xfer_id_reg == ID_MAX) ? '0 : xfer_id_reg + 1'b1;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt_reg;
  logic          timeout_err_reg;

  // The counter holds TIMEOUT-1 during the last allowed WAIT cycle, so it
  // reaches TIMEOUT on the same edge that leaves WAIT.
  assign wait_expired = (state_reg == ST_WAIT) && (wait_cnt_reg == T_LAST);

  // WAIT-state cycle counter: cleared in LAUNCH, counts every WAIT cycle.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_LAUNCH) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Sticky error flag, set when a wait expires without hs_done.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      timeout_err_reg <= 1'b0;
    end else if (wait_expired && !hs_done) begin
      timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign wait_expired = 1'b0;
`endif

  // Main sequencer: grant, launch, wait for the channel, acknowledge.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      ack_reg       <= '0;
      hs_start_reg  <= 1'b0;
      xfer_data_reg <= '0;
      xfer_id_reg   <= '0;
    end else begin
      ack_reg      <= '0;
      hs_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            state_reg     <= ST_LAUNCH;
            xfer_id_reg   <= grant_idx;
            xfer_data_reg <= grant_data;
            hs_start_reg  <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hs_done || wait_expired) begin
            state_reg <= ST_ACK;
            ack_reg   <= ack_onehot;
          end
        end
        ST_ACK: begin
          state_reg  <= ST_IDLE;
          rr_ptr_reg <= rr_next;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_reg;
  assign hs_start  = hs_start_reg;
  assign xfer_data = xfer_data_reg;
  assign xfer_id   = xfer_id_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hs_channel_arbiter.sv
// Testbench for hs_channel_arbiter (N=4, W=8, TIMEOUT=8).
// Stimulus pushes the expected grants into scoreboard queues; a monitor pops
// and compares whenever hs_start or ack is presented. Directed cycle checks
// cover reset, exact timing, spurious done and reset mid-transfer. The
// timeout scenario runs only when HS_ARB_TIMEOUT_EN is defined.
module tb_hs_channel_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk_wr = 1'b0;
  logic           rst_wr = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic           hs_start;
  logic           hs_done = 1'b0;
  logic [W-1:0]   xfer_data;
  logic [1:0]     xfer_id;
  logic           busy;
`ifdef HS_ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t start_q[$];
  exp_t ack_q[$];

  // Behavioural requester / channel controls (all driven from the main process)
  bit       chan_auto   = 1'b0;
  bit       spur_in_ack = 1'b0;
  bit       reraise_en  = 1'b0;
  int       chan_lat    = 2;
  int       chan_cnt    = 0;
  bit [N-1:0] pending   = '0;

  hs_channel_arbiter #(.N(N), .W(W), .TIMEOUT(8)) dut (
    .clk_wr     (clk_wr),
    .rst_wr     (rst_wr),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .hs_start   (hs_start),
    .hs_done    (hs_done),
    .xfer_data  (xfer_data),
    .xfer_id    (xfer_id),
    .busy       (busy)
`ifdef HS_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic expect_start(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.ack = 4'h0; e.id = id; e.data = d;
    start_q.push_back(e);
  endtask

  task automatic expect_xfer(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.ack = 4'(1) << id; e.id = id; e.data = d;
    expect_start(id, d);
    ack_q.push_back(e);
  endtask

  // Advance to the next falling edge, then apply requester and channel behaviour.
  task automatic tick();
    @(negedge clk_wr);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
        if (reraise_en) pending[i] = 1'b1;
      end else if (pending[i]) begin
        if (reraise_en) req[i] = 1'b1;
        pending[i] = 1'b0;
      end
    end
    if (chan_auto) begin
      hs_done = 1'b0;
      if (hs_start) chan_cnt = chan_lat;
      else if (chan_cnt > 0) begin
        chan_cnt--;
        if (chan_cnt == 0) hs_done = 1'b1;
      end
      if (spur_in_ack && ack != '0) hs_done = 1'b1;
    end
  endtask

  task automatic wait_drain(input int max, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((ack_q.size() != 0 || busy) && n < max);
    check({name, "_drain"}, ack_q.size(), 0);
  endtask

  // Scoreboard monitor: compare every presented start/ack against the queues.
  always @(negedge clk_wr) begin
    exp_t e;
    if (!rst_wr) begin
      if (hs_start) begin
        if (start_q.size() == 0) begin
          total++; bad++;
          $display("FAIL start_unexpected: got start id=%0d, expected none", xfer_id);
        end else begin
          e = start_q.pop_front();
          $display("start id=%0d data=%02h", xfer_id, xfer_data);
          check("start_id", xfer_id, e.id);
          check("start_data", xfer_data, e.data);
        end
      end
      if (ack != '0) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got ack=%b, expected none", ack);
        end else begin
          e = ack_q.pop_front();
          $display("ack=%b id=%0d data=%02h", ack, xfer_id, xfer_data);
          check("ack_vec", ack, e.ack);
          check("ack_id", xfer_id, e.id);
          check("ack_data", xfer_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ack", ack, 0);
    check("rst_start", hs_start, 0);
    check("rst_busy", busy, 0);
    check("rst_data", xfer_data, 0);
    check("rst_id", xfer_id, 0);
`ifdef HS_ARB_TIMEOUT_EN
    check("rst_terr", timeout_err, 0);
`endif
    rst_wr = 1'b0;
    tick();

    // Single requester, cycle-exact timing (cycle 0 = this cycle)
    set_data(2, 8'hA5); req[2] = 1'b1; expect_xfer(2'd2, 8'hA5);
    tick();
    check("t1_start", hs_start, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_id", xfer_id, 2);
    check("t1_data", xfer_data, 8'hA5);
    check("t1_start_low", hs_start, 0);
    repeat (4) tick();
    check("t1_no_early_ack", ack, 0);
    hs_done = 1'b1;
    tick();
    hs_done = 1'b0;
    check("t1_ack", ack, 4'b0100);
    tick();
    check("t1_ack_once", ack, 0);
    check("t1_idle", busy, 0);

    // Spurious done in IDLE
    hs_done = 1'b1;
    tick();
    hs_done = 1'b0;
    check("sp_idle_busy", busy, 0);
    check("sp_idle_ack", ack, 0);
    check("sp_idle_data", xfer_data, 8'hA5);

    // Requester 3 (pointer is 3), with a spurious done during ACK
    chan_auto = 1'b1; chan_lat = 3; chan_cnt = 0; spur_in_ack = 1'b1;
    set_data(3, 8'h33); req[3] = 1'b1; expect_xfer(2'd3, 8'h33);
    wait_drain(40, "t3");
    spur_in_ack = 1'b0;
    tick();
    check("sp_ack_busy", busy, 0);
    check("sp_ack_ack", ack, 0);
    check("sp_ack_data", xfer_data, 8'h33);

    // Pointer wrapped to 0: requests 0 and 3 together -> 0 then 3
    chan_lat = 2;
    set_data(0, 8'h11); set_data(3, 8'h3D);
    req[0] = 1'b1; req[3] = 1'b1;
    expect_xfer(2'd0, 8'h11); expect_xfer(2'd3, 8'h3D);
    wait_drain(60, "wrap");

    // Round-robin fairness: all requesters continuously re-raised
    for (int i = 0; i < N; i++) set_data(i, 8'h40 + 8'(i));
    expect_xfer(2'd0, 8'h40); expect_xfer(2'd1, 8'h41);
    expect_xfer(2'd2, 8'h42); expect_xfer(2'd3, 8'h43);
    expect_xfer(2'd0, 8'h40);
    reraise_en = 1'b1; req = 4'hF;
    for (int n = 0; n < 200 && ack_q.size() != 0; n++) tick();
    reraise_en = 1'b0; pending = '0; req = '0;
    wait_drain(20, "fair");
    check("fair_last_id", xfer_id, 0);

    // Reset asserted mid-WAIT (pointer is 1 before reset)
    chan_auto = 1'b0; chan_cnt = 0;
    set_data(2, 8'h5A); req[2] = 1'b1; expect_start(2'd2, 8'h5A);
    tick(); tick(); tick();
    check("rw_busy_before", busy, 1);
    rst_wr = 1'b1; req = '0;
    #1;
    check("rw_ack", ack, 0);
    check("rw_start", hs_start, 0);
    check("rw_busy", busy, 0);
    check("rw_id", xfer_id, 0);
    check("rw_data", xfer_data, 0);
    tick();
    rst_wr = 1'b0;
    chan_auto = 1'b1; chan_cnt = 0; chan_lat = 2;
    set_data(0, 8'hC0); set_data(1, 8'hC1);
    req[0] = 1'b1; req[1] = 1'b1;
    expect_xfer(2'd0, 8'hC0); expect_xfer(2'd1, 8'hC1);
    wait_drain(60, "post_rst");

`ifdef HS_ARB_TIMEOUT_EN
    // Timeout with TIMEOUT=8: ack 8 cycles after WAIT is entered
    check("to_err_clear", timeout_err, 0);
    chan_auto = 1'b0; chan_cnt = 0;
    set_data(1, 8'h77); req[1] = 1'b1; expect_xfer(2'd1, 8'h77);
    tick();
    tick();
    repeat (7) tick();
    check("to_no_early_ack", ack, 0);
    check("to_err_early", timeout_err, 0);
    tick();
    check("to_ack", ack, 4'b0010);
    check("to_err", timeout_err, 1);
    tick();
    hs_done = 1'b1;
    tick();
    hs_done = 1'b0;
    check("to_late_done_busy", busy, 0);
    chan_auto = 1'b1; chan_cnt = 0;
    set_data(2, 8'h99); req[2] = 1'b1; expect_xfer(2'd2, 8'h99);
    wait_drain(40, "to_after");
    check("to_err_sticky", timeout_err, 1);
`endif

    check("start_q_empty", start_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_channel_arbiter.md
# hs_channel_arbiter

Round-robin arbiter and sequencer that shares one pulse-handshake CDC channel among N write-domain requesters. It grants one requester, latches that requester's payload into a stable holding register and pulses the channel's `start`. It then waits for the channel's `done` and acknowledges the requester. It sits entirely in the clk_wr domain, between producer blocks and the handshake synchronizer; the read domain samples `xfer_data`/`xfer_id` on its read pulse.

## Interface
- `N`, 4: number of requesters, 2..16.
- `W`, 8: payload width per requester.
- `TIMEOUT`, 1023: WAIT-state cycle limit, used only when the timeout feature is compiled in.
- `clk_wr` in 1: write-domain clock.
- `rst_wr` in 1: asynchronous, active-high reset; clock clk_wr.
- `req` in N: per-requester request level, held until the matching `ack`.
- `req_data` in N*W: payloads; requester i occupies bits [i*W +: W]; must be stable while `req[i]` is high.
- `ack` out N: one-hot, one-cycle pulse; transfer for requester i is complete.
- `hs_start` out 1: one-cycle start pulse to the handshake channel.
- `hs_done` in 1: one-cycle done pulse from the handshake channel.
- `xfer_data` out W: latched payload, crosses to the read domain.
- `xfer_id` out $clog2(N): latched requester index.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky error flag; present only with HS_ARB_TIMEOUT_EN.

## Operation
- States:
  - IDLE: if any `req` is set, grant the first set bit searching upward from `rr_ptr` with wrap; latch `xfer_data` and `xfer_id`; go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: `hs_start`=1 for exactly this cycle; go to WAIT.
  - WAIT: on `hs_done`=1, go to ACK; otherwise stay.
  - ACK: `ack[xfer_id]`=1 for exactly this cycle; `rr_ptr` <= (xfer_id+1) mod N; go to IDLE.
- `req` is ignored in LAUNCH, WAIT and ACK. The requester drops `req` at the clock edge that ends its `ack` cycle, so IDLE never re-grants it.
- `rr_ptr` width is $clog2(N); wrap is explicit for non-power-of-2 N.
- `xfer_data`/`xfer_id` change only on the IDLE→LAUNCH edge. They are held through WAIT, ACK and any idle gap.
- `hs_done` in IDLE, LAUNCH or ACK is ignored and causes no state change.
- `req` bits that drop before being granted are simply not granted; there is no error.
- Reset values: state IDLE, `rr_ptr`=0, `ack`=0, `hs_start`=0, `busy`=0, `xfer_data`=0, `xfer_id`=0, `timeout_err`=0.
- Reset asserted mid-transfer returns to IDLE immediately, with no `ack` for the in-flight request.

## Timing
- `req` rises in cycle 0 while the arbiter is IDLE:
  - LAUNCH is in cycle 1, with `hs_start` high in cycle 1.
  - WAIT starts in cycle 2.
- `hs_done` seen in WAIT in cycle k: `ack` is high in cycle k+1 (ACK), and the arbiter is IDLE in cycle k+2.
- Minimum grant-to-grant spacing is 4 cycles plus the channel round trip.
- All outputs are registered except `busy`, which is decoded from the state register.

## Configuration
- `HS_ARB_TIMEOUT_EN` defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on LAUNCH and increments in WAIT.
  - If it reaches TIMEOUT with no `hs_done`, go to ACK, pulse `ack[xfer_id]`, and set `timeout_err`, which is sticky until `rst_wr`.
  - A late `hs_done` arriving afterwards is ignored under the normal ignore rule.
- `HS_ARB_TIMEOUT_EN` undefined: the `timeout_err` port and counter are absent, and WAIT waits indefinitely.

## Test plan
- **Single requester:** N=4, `req[2]`=1 with data 0xA5 at cycle 0; `hs_done` at cycle 6. Expect `hs_start` at cycle 1, `xfer_id`=2 and `xfer_data`=0xA5 from cycle 2, and `ack`=4'b0100 at cycle 7 only.
- **Round-robin fairness:** all four `req` held high continuously, each re-raised after its `ack`. Expect grant order 0,1,2,3,0 with no requester granted twice in a row.
- **Pointer wrap with sparse requests:** `req[3]` completes, then `req[0]` and `req[3]` are raised together. Expect 0 to be granted first (pointer wrapped to 0), then 3.
- **Spurious done:** `hs_done` pulsed in IDLE and in ACK. Expect no state change and no extra `ack`; `xfer_data` unchanged.
- **Reset mid-WAIT:** `rst_wr` asserted in WAIT. Expect all outputs 0 immediately, no `ack` for the in-flight requester, and the next grant to search from requester 0.
- **Timeout (HS_ARB_TIMEOUT_EN, TIMEOUT=8):** `hs_done` withheld. Expect `ack` 8 cycles after entering WAIT and `timeout_err`=1, still 1 after later successful transfers.
